// File: rtl/adc_axis_framer.sv
// adc_axis_framer
//   Frames a strobed 16-bit ADC sample stream into fixed-length AXI-stream
//   frames for the DDC input FIFO. Each accepted sample is tagged with its
//   in-frame index and queued in a first-word-fall-through FIFO. The FIFO
//   head is read straight out of the storage registers, so there is no
//   combinational path from adc_* to axis_*.
//
//   Build option: define ADC_FRAMER_RAMP_TEST_EN to add the ramp_sel input.
//   When ramp_sel is high, an internal ramp replaces adc_data as the sample.
//
//   U_DLY is kept so existing instantiations still elaborate. This block
//   puts no delays on its assignments.
//
//   state | meaning
//   IDLE  | waiting for enable; ADC strobes are ignored
//   RUN   | capturing samples into frames
//   FLUSH | enable dropped mid-frame; finish the frame, then go to IDLE

module adc_axis_framer #(
  parameter int U_DLY     = 1,
  parameter int FRAME_LEN = 256,
  parameter int FIFO_AW   = 4
) (
  input  logic        axis_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        adc_valid,
  input  logic [15:0] adc_data,
`ifdef ADC_FRAMER_RAMP_TEST_EN
  input  logic        ramp_sel,
`endif
  output logic        axis_tvalid,
  input  logic        axis_tready,
  output logic [31:0] axis_tdata,
  output logic        axis_tlast,
  output logic [15:0] ovf_cnt,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  // Reject parameter sets the index or pointer logic cannot represent.
  if (FRAME_LEN < 2 || FRAME_LEN > 65536 || FIFO_AW < 1 || U_DLY < 0) begin : g_param_check
    $error("adc_axis_framer: illegal parameter set");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Each entry holds {tlast, index[15:0], sample[15:0]}.
  logic [32:0]        fifo_mem [DEPTH];
  logic [FIFO_AW:0]   wr_ptr_q;
  logic [FIFO_AW:0]   rd_ptr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [15:0]        ovf_q;
  logic [15:0]        frame_q;

  logic               fifo_empty;
  logic               fifo_full;
  logic               wr_try;
  logic               wr_ok;
  logic               wr_drop;
  logic               rd_ok;
  logic               idx_at_last;
  logic               frame_done;
  logic               start_run;
  logic [15:0]        sample_d;
  logic [32:0]        wr_word;
  logic [32:0]        head_word;

  // The pointers carry one extra wrap bit. Full means the wrap bits differ
  // while the addresses are equal. Full is taken before this cycle's read,
  // so a strobe on a full FIFO is dropped even if a beat leaves that cycle.
  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                       (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

  assign wr_try      = adc_valid && (state_q != IDLE);
  assign wr_ok       = wr_try && !fifo_full;
  assign wr_drop     = wr_try && fifo_full;
  assign rd_ok       = !fifo_empty && axis_tready;
  assign idx_at_last = (idx_q == IDX_LAST);
  assign frame_done  = wr_ok && idx_at_last;
  assign start_run   = (state_q == IDLE) && enable;

`ifdef ADC_FRAMER_RAMP_TEST_EN
  logic [15:0] ramp_q;

  // Ramp for bring-up: restarts on entry to RUN and counts accepted writes.
  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_q <= '0;
    end else if (start_run) begin
      ramp_q <= '0;
    end else if (wr_ok) begin
      ramp_q <= ramp_q + 16'd1;
    end
  end

  assign sample_d = ramp_sel ? ramp_q : adc_data;
`else
  assign sample_d = adc_data;
`endif

  assign wr_word = {idx_at_last, 16'(idx_q), sample_d};

  // State register.
  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. A frame completed in the same cycle that enable drops goes
  // straight to IDLE. Otherwise FLUSH finishes the frame so the consumer
  // never sees a partial frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = frame_done ? IDLE : FLUSH;
        end
      end
      FLUSH: begin
        if (frame_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // In-frame index. It advances only on accepted writes and wraps after the
  // last sample of a frame.
  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (start_run) begin
      idx_q <= '0;
    end else if (wr_ok) begin
      idx_q <= idx_at_last ? '0 : idx_q + 1'b1;
    end
  end

  // Overflow counter. It saturates, holds in IDLE, and clears on entry to RUN.
  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else if (start_run) begin
      ovf_q <= '0;
    end else if (wr_drop && (ovf_q != 16'hFFFF)) begin
      ovf_q <= ovf_q + 16'd1;
    end
  end

  // Completed-frame counter. It steps on the tlast handshake and wraps.
  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
    end else if (rd_ok && head_word[32]) begin
      frame_q <= frame_q + 16'd1;
    end
  end

  // FIFO storage. No reset is needed because the output is masked while
  // the FIFO is empty.
  always_ff @(posedge axis_clk) begin
    if (wr_ok) begin
      fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= wr_word;
    end
  end

  // FIFO pointers. Reset empties the queue immediately, mid-frame or not.
  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign head_word   = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
  assign axis_tvalid = !fifo_empty;
  assign axis_tdata  = fifo_empty ? 32'd0 : head_word[31:0];
  assign axis_tlast  = !fifo_empty && head_word[32];

  assign ovf_cnt     = ovf_q;
  assign frame_cnt   = frame_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule
